conv2d_rmst_arb: RTL

//  Shares the single read-master (rmst_ctrl_*/rmst_user_*) of a conv2d layer between two

---
 rtl/conv2d_rmst_arb_if.sv | 42 ++++
 rtl/conv2d_rmst_arb.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/conv2d_rmst_arb_if.sv
// conv2d_rmst_arb_if
//   Bundles the read-master control and user-FIFO signals that sit between the
//   conv2d burst arbiter and the single shared read master.
//   Parameters: AW = byte address/length width, DW = data beat width.
//   Modports:
//     master : arbiter side, drives ctrl_* and read_buffer, receives done/data/available
//     slave  : read-master side, the mirror image
interface conv2d_rmst_arb_if #(
    parameter int AW = 30,
    parameter int DW = 128
);
    logic          rmst_ctrl_fixed_location;
    logic [AW-1:0] rmst_ctrl_read_base;
    logic [AW-1:0] rmst_ctrl_read_length;
    logic          rmst_ctrl_go;
    logic          rmst_ctrl_done;
    logic          rmst_user_read_buffer;
    logic [DW-1:0] rmst_user_buffer_data;
    logic          rmst_user_data_available;

    modport master (
        output rmst_ctrl_fixed_location,
        output rmst_ctrl_read_base,
        output rmst_ctrl_read_length,
        output rmst_ctrl_go,
        input  rmst_ctrl_done,
        output rmst_user_read_buffer,
        input  rmst_user_buffer_data,
        input  rmst_user_data_available
    );

    modport slave (
        input  rmst_ctrl_fixed_location,
        input  rmst_ctrl_read_base,
        input  rmst_ctrl_read_length,
        input  rmst_ctrl_go,
        output rmst_ctrl_done,
        input  rmst_user_read_buffer,
        output rmst_user_buffer_data,
        output rmst_user_data_available
    );
endinterface

// File: rtl/conv2d_rmst_arb.sv
// conv2d_rmst_arb
//   Shares one read master between two conv2d burst requesters:
//   port 0 = weight prefetch, port 1 = input-pixel fetch. Whole bursts are
//   arbitrated, the master is started with a one-cycle go pulse, and returned
//   beats are steered to the granted port with that port's backpressure.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     reqN_valid/base/len      burst request (byte base, byte length, DW/8 aligned)
//     reqN_ready               one-cycle accept pulse
//     rdN_data/valid/ready     returned beat stream for port N
//     rdN_last                 qualifies the final beat of the burst
//     rdN_done                 one-cycle pulse when port N's burst is retired
//     rmst                     read-master interface (master modport)
//   Build option:
//     CONV2D_RMST_ARB_WPRIO_EN  defined   -> fixed priority, port 0 wins ties
//                               undefined -> round-robin between the ports
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | waiting for a request; arbitrates and latches base/length
//   S_GO    | issues the one-cycle go pulse to the read master
//   S_XFER  | steers FIFO beats to the granted port until all are popped
//   S_DRAIN | waits for the master to report done, then pulses rdN_done
module conv2d_rmst_arb #(
    parameter int AW = 30,
    parameter int DW = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_base,
    input  logic [AW-1:0] req0_len,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_base,
    input  logic [AW-1:0] req1_len,
    output logic          req1_ready,
    output logic [DW-1:0] rd0_data,
    output logic          rd0_valid,
    input  logic          rd0_ready,
    output logic          rd0_last,
    output logic          rd0_done,
    output logic [DW-1:0] rd1_data,
    output logic          rd1_valid,
    input  logic          rd1_ready,
    output logic          rd1_last,
    output logic          rd1_done,
    conv2d_rmst_arb_if.master rmst
);
    localparam int LB = $clog2(DW / 8);
    localparam int BW = AW - LB;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GO,
        S_XFER,
        S_DRAIN
    } state_t;

    state_t        state;
    logic          grant;
    logic          last_grant;
    logic [BW-1:0] beats_left;
    logic [1:0]    req_ready_q;
    logic [1:0]    rd_done_q;
    logic          go_q;
    logic          zero_pend;
    logic [AW-1:0] base_q;
    logic [AW-1:0] len_q;

    logic          win;
    logic [AW-1:0] win_base;
    logic [AW-1:0] win_len;
    logic          win_zero;
    logic          arb_en;
    logic          xfer_valid;
    logic          pop;
    logic          last_beat;

    always_comb begin
`ifdef CONV2D_RMST_ARB_WPRIO_EN
        win = ~req0_valid;
`else
        if (req0_valid && req1_valid) begin
            win = ~last_grant;
        end else begin
            win = ~req0_valid;
        end
`endif
    end

    assign win_base = win ? req1_base : req0_base;
    assign win_len  = win ? req1_len  : req0_len;
    assign win_zero = (win_len[AW-1:LB] == '0);

    // The accepted requester still holds valid during its ready cycle, and a
    // zero-length grant still owes its done pulse, so hold off arbitration
    // until both have passed; likewise for the done pulse after a burst.
    assign arb_en = (state == S_IDLE) && (req0_valid || req1_valid) &&
                    (req_ready_q == 2'b00) && !zero_pend && (rd_done_q == 2'b00);

    assign xfer_valid = (state == S_XFER) && rmst.rmst_user_data_available &&
                        (beats_left != '0);
    assign last_beat  = (beats_left == BW'(1));
    assign pop        = xfer_valid && (grant ? rd1_ready : rd0_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            grant       <= 1'b0;
            last_grant  <= 1'b1;
            beats_left  <= '0;
            req_ready_q <= 2'b00;
            rd_done_q   <= 2'b00;
            go_q        <= 1'b0;
            zero_pend   <= 1'b0;
            base_q      <= '0;
            len_q       <= '0;
        end else begin
            req_ready_q <= 2'b00;
            rd_done_q   <= 2'b00;
            go_q        <= 1'b0;
            zero_pend   <= 1'b0;
            if (zero_pend) begin
                rd_done_q[grant] <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (arb_en) begin
                        req_ready_q[win] <= 1'b1;
                        grant            <= win;
                        base_q           <= win_base;
                        len_q            <= win_len;
                        beats_left       <= win_len[AW-1:LB];
                        if (win_zero) begin
                            zero_pend  <= 1'b1;
                            last_grant <= win;
                        end else begin
                            state <= S_GO;
                        end
                    end
                end
                S_GO: begin
                    go_q  <= 1'b1;
                    state <= S_XFER;
                end
                S_XFER: begin
                    if (pop) begin
                        beats_left <= beats_left - BW'(1);
                    end
                    if ((beats_left == '0) || (pop && last_beat)) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Only reached after at least one XFER cycle, so a done
                    // level left over from the previous idle period has
                    // already been stepped past.
                    if (rmst.rmst_ctrl_done) begin
                        rd_done_q[grant] <= 1'b1;
                        last_grant       <= grant;
                        state            <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign req0_ready = req_ready_q[0];
    assign req1_ready = req_ready_q[1];
    assign rd0_done   = rd_done_q[0];
    assign rd1_done   = rd_done_q[1];

    assign rd0_data  = rmst.rmst_user_buffer_data;
    assign rd1_data  = rmst.rmst_user_buffer_data;
    assign rd0_valid = xfer_valid && !grant;
    assign rd1_valid = xfer_valid && grant;
    assign rd0_last  = xfer_valid && !grant && last_beat;
    assign rd1_last  = xfer_valid && grant && last_beat;

    assign rmst.rmst_ctrl_fixed_location = 1'b0;
    assign rmst.rmst_ctrl_read_base      = base_q;
    assign rmst.rmst_ctrl_read_length    = len_q;
    assign rmst.rmst_ctrl_go             = go_q;
    assign rmst.rmst_user_read_buffer    = pop;
endmodule
